// File: rtl/fifo_framer_pkg.sv
// Shared types for the dual-clock FIFO write-side framer.
// The TRL state is only reachable when FRAMER_CSUM_EN is defined.
package fifo_framer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        PAD  = 3'd3,
        TRL  = 3'd4
    } framer_state_e;

    // Pad words are all zeros, so they leave the XOR checksum unchanged.
    localparam logic PAD_BIT = 1'b0;

endpackage

// File: rtl/fifo_wr_framer.sv
// Write-side framer: writes a length header, the payload words (zero-padded if short) and an optional
// XOR trailer into the FIFO. Define FRAMER_CSUM_EN to build with the trailer.
//
// state | meaning
// IDLE  | waiting for a frame command; cmd_ready high
// HDR   | writing the length header word
// DATA  | passing payload words from the source to the FIFO
// PAD   | source ended early; writing zero words up to len_q
// TRL   | writing the checksum trailer (FRAMER_CSUM_EN only)
module fifo_wr_framer
    import fifo_framer_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int CNT_W = 16
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DSIZE-1:0] cmd_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DSIZE-1:0] s_data,
    input  logic             s_last,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    input  logic             wfull,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             len_err,
    output logic             busy
);

`ifdef FRAMER_CSUM_EN
    localparam framer_state_e EOP_STATE = TRL;
`else
    localparam framer_state_e EOP_STATE = IDLE;
`endif

    framer_state_e    state_q;
    logic [DSIZE-1:0] len_q;
    logic [DSIZE-1:0] rem_cnt_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic             len_err_q;
`ifdef FRAMER_CSUM_EN
    logic [DSIZE-1:0] csum_q;
`endif

    logic [DSIZE-1:0] rem_cnt_d;
    logic             at_len;
    logic             frame_end;

    // The word being written now completes the count when rem_cnt_q + 1 reaches len_q.
    assign rem_cnt_d = rem_cnt_q + DSIZE'(1);
    assign at_len    = (rem_cnt_d == len_q);

    always_comb begin
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        winc      = 1'b0;
        wdata     = '0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            HDR: begin
                winc  = !wfull;
                wdata = len_q;
            end
            DATA: begin
                s_ready = !wfull;
                winc    = s_valid && !wfull;
                wdata   = s_data;
            end
            PAD: begin
                winc  = !wfull;
                wdata = {DSIZE{PAD_BIT}};
            end
`ifdef FRAMER_CSUM_EN
            TRL: begin
                winc  = !wfull;
                wdata = csum_q;
            end
`endif
            default: begin
                winc = 1'b0;
            end
        endcase
    end

    // Identifies the cycle carrying the final FIFO write of a frame.
    always_comb begin
        frame_end = 1'b0;
`ifdef FRAMER_CSUM_EN
        frame_end = winc && (state_q == TRL);
`else
        case (state_q)
            HDR:     frame_end = winc && (len_q == '0);
            DATA:    frame_end = winc && at_len;
            PAD:     frame_end = winc && at_len;
            default: frame_end = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            rem_cnt_q   <= '0;
            frame_cnt_q <= '0;
            len_err_q   <= 1'b0;
`ifdef FRAMER_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            if (frame_end) begin
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        len_q     <= cmd_len;
                        rem_cnt_q <= '0;
`ifdef FRAMER_CSUM_EN
                        csum_q    <= '0;
`endif
                        state_q   <= HDR;
                    end
                end
                HDR: begin
                    if (winc) begin
                        state_q <= (len_q == '0) ? EOP_STATE : DATA;
                    end
                end
                DATA: begin
                    if (winc) begin
                        rem_cnt_q <= rem_cnt_d;
`ifdef FRAMER_CSUM_EN
                        csum_q    <= csum_q ^ s_data;
`endif
                        if (at_len) begin
                            if (!s_last) begin
                                len_err_q <= 1'b1;
                            end
                            state_q <= EOP_STATE;
                        end else if (s_last) begin
                            len_err_q <= 1'b1;
                            state_q   <= PAD;
                        end
                    end
                end
                PAD: begin
                    if (winc) begin
                        rem_cnt_q <= rem_cnt_d;
                        if (at_len) begin
                            state_q <= EOP_STATE;
                        end
                    end
                end
`ifdef FRAMER_CSUM_EN
                TRL: begin
                    if (winc) begin
                        state_q <= IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign len_err   = len_err_q;
    assign busy      = (state_q != IDLE);

endmodule
